// File: rtl/ceespu_pkg.sv
// Shared definitions for the ceespu data-memory responder: access size
// encodings, the extension-select bit and the responder FSM states.
package ceespu_pkg;

  // Access size carried in I_selMem[1:0]; code 3 is treated as a word.
  localparam logic [1:0] MEM_WORD = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_BYTE = 2'd2;

  // I_selMem bit choosing zero-extension (1) over sign-extension (0).
  localparam int SEL_EXT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/ceespu_dmem_ram.sv
// Single-port synchronous RAM, 32-bit words with four byte-lane write
// enables and a registered read port that only updates when i_re is set.
module ceespu_dmem_ram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  i_clk,
  input  logic [3:0]            i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];

  // Byte-lane writes and registered read; the read register holds between reads.
  // NOTE: no reset here on purpose -- a reset would turn the array into
  // flops instead of a RAM macro, and the contents are defined by software.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_we[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
    end
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/ceespu_dmem.sv
// ceespu data-memory responder: accepts load/store requests from execute,
// writes stores into the byte-lane RAM, and returns aligned, extended load
// data after a programmable number of wait states.
module ceespu_dmem
  import ceespu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_memE,
  input  logic [3:0]  I_memWe,
  input  logic [31:0] I_address,
  input  logic [31:0] I_storeData,
  input  logic [2:0]  I_selMem,
  output logic [31:0] O_loadData,
  output logic        O_valid,
  output logic        O_busy
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  dmem_state_t r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic [1:0]  r_lane, r_size;
  logic        r_zext;
  logic [31:0] r_hold;
  logic [31:0] w_rdata, w_ext;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic        w_accept, w_load, w_store;
  logic [3:0]  w_we;
  logic        w_unused_addr;

  // Busy and valid decode straight from the state register, so neither
  // ever depends combinationally on the request inputs.
  assign O_busy   = (r_state == ST_WAIT);
  assign O_valid  = (r_state == ST_RESP);
  assign w_accept = I_memE && !O_busy;
  assign w_store  = w_accept && (I_memWe != 4'b0000);
  assign w_load   = w_accept && (I_memWe == 4'b0000);
  assign w_we     = w_store ? I_memWe : 4'b0000;

  // Address bits above the RAM depth alias onto the same words.
  assign w_unused_addr = ^I_address[31:ADDR_WIDTH+2];

  ceespu_dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk   (I_clk),
    .i_we    (w_we),
    .i_re    (w_load),
    .i_addr  (I_address[ADDR_WIDTH+1:2]),
    .i_wdata (I_storeData),
    .o_rdata (w_rdata)
  );

  // Next-state and wait-counter logic for the load response sequence.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (r_state == ST_RESP) w_state_next = ST_IDLE;
        if (w_load) begin
          w_state_next = (WS == 3'd0) ? ST_RESP : ST_WAIT;
          w_cnt_next   = WS;
        end
      end
      ST_WAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_state_next = ST_RESP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any load in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture byte offset and size/extension of each accepted load.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_lane <= 2'd0;
      r_size <= MEM_WORD;
      r_zext <= 1'b0;
    end else if (w_load) begin
      r_lane <= I_address[1:0];
      r_size <= I_selMem[1:0];
      r_zext <= I_selMem[SEL_EXT_BIT];
    end
  end

  // Lane selection and extension of the RAM read word.
  always_comb begin
    w_half = r_lane[0] ? w_rdata[31:16] : w_rdata[15:0];
    w_byte = w_rdata[{r_lane, 3'b000} +: 8];
    w_ext  = w_rdata;
    case (r_size)
      MEM_WORD: w_ext = w_rdata;
      MEM_HALF: w_ext = r_zext ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      MEM_BYTE: w_ext = r_zext ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      default:  w_ext = w_rdata;
    endcase
  end

  // Remember the last returned value so O_loadData holds between valids.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) r_hold <= 32'h0;
    else if (O_valid) r_hold <= w_ext;
  end

  assign O_loadData = O_valid ? w_ext : r_hold;

endmodule

// File: tb/tb_ceespu_dmem.sv
// Self-checking bench for ceespu_dmem: one instance with no wait states
// (directed and randomized traffic against a byte-array model) and one
// with three wait states (busy/hold behaviour and reset abort).
module tb_ceespu_dmem;

  localparam int AW = 14;
  localparam longint SPAN = longint'(1) << (AW + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        e0, e3;
  logic [3:0]  we0, we3;
  logic [31:0] a0, a3, sd0, sd3;
  logic [2:0]  sel0, sel3;
  logic [31:0] ld0, ld3;
  logic        v0, v3, b0, b3;

  int n_checks = 0;
  int n_fail   = 0;

  // Byte-addressed models of each instance's memory (aliased address space).
  int mdl0 [longint];
  int mdl3 [longint];

  ceespu_dmem #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .I_clk(clk), .I_rst(rst_n), .I_memE(e0), .I_memWe(we0), .I_address(a0),
    .I_storeData(sd0), .I_selMem(sel0), .O_loadData(ld0), .O_valid(v0), .O_busy(b0));

  ceespu_dmem #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
    .I_clk(clk), .I_rst(rst_n), .I_memE(e3), .I_memWe(we3), .I_address(a3),
    .I_storeData(sd3), .I_selMem(sel3), .O_loadData(ld3), .O_valid(v3), .O_busy(b3));

  function automatic longint word_base(input logic [31:0] addr);
    longint a;
    a = longint'(addr) % SPAN;
    return a - (a % 4);
  endfunction

  function automatic int mbyte(input bit d3, input longint a);
    return d3 ? mdl3[a] : mdl0[a];
  endfunction

  function automatic void mstore(input bit d3, input logic [31:0] addr,
                                 input logic [3:0] we, input logic [31:0] data);
    longint base;
    base = word_base(addr);
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        if (d3) mdl3[base + k] = int'(data[8*k +: 8]);
        else    mdl0[base + k] = int'(data[8*k +: 8]);
      end
    end
  endfunction

  // Expected load value from the model using plain arithmetic.
  function automatic logic [31:0] exp_load(input bit d3, input logic [31:0] addr,
                                           input logic [2:0] sel);
    longint base, off, v, lane;
    base = word_base(addr);
    off  = longint'(addr) % 4;
    case (int'(sel) % 4)
      1: begin
        lane = (off % 2 == 1) ? 2 : 0;
        v = mbyte(d3, base + lane) + 256 * mbyte(d3, base + lane + 1);
        if (!sel[2] && v >= 32768) v = v - 65536;
      end
      2: begin
        v = mbyte(d3, base + off);
        if (!sel[2] && v >= 128) v = v - 256;
      end
      default: begin
        v = mbyte(d3, base) + 256 * mbyte(d3, base + 1) +
            65536 * mbyte(d3, base + 2) + 16777216 * mbyte(d3, base + 3);
      end
    endcase
    return v[31:0];
  endfunction

  logic [31:0] last0;

  task automatic store0(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    @(negedge clk);
    e0 = 1'b1; we0 = we; a0 = addr; sd0 = data; sel0 = 3'b000;
    @(posedge clk); #1;
    mstore(1'b0, addr, we, data);
    n_checks++;
    if (v0 !== 1'b0 || b0 !== 1'b0) begin
      n_fail++;
      $display("FAIL store0_no_valid addr=%h: valid=%b busy=%b required 0/0", addr, v0, b0);
    end
  endtask

  task automatic load0(input string nm, input logic [31:0] addr, input logic [2:0] sel,
                       input logic [31:0] expv);
    @(negedge clk);
    e0 = 1'b1; we0 = 4'b0000; a0 = addr; sel0 = sel; sd0 = $urandom;
    @(posedge clk); #1;
    n_checks++;
    if (v0 !== 1'b1 || ld0 !== expv) begin
      n_fail++;
      $display("FAIL %s addr=%h sel=%b: valid=%b data=%h required valid=1 data=%h",
               nm, addr, sel, v0, ld0, expv);
    end
    last0 = expv;
  endtask

  task automatic idle0();
    @(negedge clk);
    e0 = 1'b0; we0 = 4'b1111; a0 = $urandom; sd0 = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e0 = 1'b0; we0 = 4'b0; a0 = 32'h0; sd0 = 32'h0; sel0 = 3'b0;
    e3 = 1'b0; we3 = 4'b0; a3 = 32'h0; sd3 = 32'h0; sel3 = 3'b0;
    #12;
    n_checks++;
    if ({ld0, v0, b0} !== 34'h0 || {ld3, v3, b3} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_values: dut0 %h/%b/%b dut3 %h/%b/%b required all zero",
               ld0, v0, b0, ld3, v3, b3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_and_bytes();
    store0(32'h10, 4'b1111, 32'hDEADBEEF);
    load0("word_after_store", 32'h10, 3'b000, 32'hDEADBEEF);
    load0("byte_sx_0", 32'h10, 3'b010, 32'hFFFFFFEF);
    load0("byte_sx_1", 32'h11, 3'b010, 32'hFFFFFFBE);
    load0("byte_sx_2", 32'h12, 3'b010, 32'hFFFFFFAD);
    load0("byte_sx_3", 32'h13, 3'b010, 32'hFFFFFFDE);
    load0("byte_zx_3", 32'h13, 3'b110, 32'h000000DE);
    load0("word_sel3", 32'h12, 3'b011, 32'hDEADBEEF);
    idle0();
  endtask

  task automatic test_half();
    store0(32'h20, 4'b1111, 32'h12345678);
    store0(32'h21, 4'b1100, 32'h80018001);
    load0("half_sx_hi", 32'h21, 3'b001, 32'hFFFF8001);
    load0("half_zx_hi", 32'h21, 3'b101, 32'h00008001);
    load0("half_sx_lo", 32'h20, 3'b001, 32'h00005678);
    load0("word_after_half", 32'h20, 3'b000, 32'h80015678);
    idle0();
  endtask

  task automatic test_alias();
    load0("alias_word", 32'h10 + (32'h1 << (AW + 2)), 3'b000, 32'hDEADBEEF);
    load0("alias_high", 32'hFFFF0010, 3'b010, 32'hFFFFFFEF);
    idle0();
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    n_checks++;
    if (v0 !== 1'b0 || ld0 !== last0) begin
      n_fail++;
      $display("FAIL hold_between_valids: valid=%b data=%h required valid=0 data=%h",
               v0, ld0, last0);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] addr, data;
    logic [2:0]  sel;
    int          sz;
    for (int i = 0; i < 16; i++) store0(32'h100 + 32'(4 * i), 4'b1111, $urandom);
    for (int i = 0; i < 200; i++) begin
      addr = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << (AW + 2));
      if ($urandom_range(0, 2) == 0) begin
        sz = $urandom_range(0, 2);
        data = $urandom;
        if (sz == 0) store0(addr, 4'b1111, data);
        else if (sz == 1) store0(addr, addr[0] ? 4'b1100 : 4'b0011, {data[15:0], data[15:0]});
        else store0(addr, 4'b0001 << addr[1:0], {4{data[7:0]}});
      end else begin
        sel = 3'($urandom_range(0, 7));
        load0("random_load", addr, sel, exp_load(1'b0, addr, sel));
      end
    end
    idle0();
  endtask

  task automatic test_wait_states();
    @(negedge clk);
    e3 = 1'b1; we3 = 4'b1111; a3 = 32'h40; sd3 = 32'hCAFEF00D; sel3 = 3'b000;
    mstore(1'b1, 32'h40, 4'b1111, 32'hCAFEF00D);
    @(negedge clk);
    a3 = 32'h44; sd3 = 32'h13579BDF;
    mstore(1'b1, 32'h44, 4'b1111, 32'h13579BDF);
    @(negedge clk);
    we3 = 4'b0000; a3 = 32'h40;
    @(posedge clk); #1;
    for (int req = 0; req < 2; req++) begin
      for (int k = 1; k <= 3; k++) begin
        n_checks++;
        if (b3 !== 1'b1 || v3 !== 1'b0) begin
          n_fail++;
          $display("FAIL ws_busy req%0d cycle%0d: busy=%b valid=%b required 1/0", req, k, b3, v3);
        end
        if (req == 0 && k == 1) begin
          @(negedge clk);
          a3 = 32'h44;
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if (v3 !== 1'b1 || b3 !== 1'b0 || ld3 !== exp_load(1'b1, req == 0 ? 32'h40 : 32'h44, 3'b000)) begin
        n_fail++;
        $display("FAIL ws_valid req%0d: valid=%b busy=%b data=%h required 1/0/%h", req, v3, b3,
                 ld3, exp_load(1'b1, req == 0 ? 32'h40 : 32'h44, 3'b000));
      end
      if (req == 1) begin
        @(negedge clk);
        e3 = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (v3 !== 1'b0 || b3 !== 1'b0) begin
      n_fail++;
      $display("FAIL ws_idle_after: valid=%b busy=%b required 0/0", v3, b3);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    @(negedge clk);
    e3 = 1'b1; we3 = 4'b0000; a3 = 32'h44; sel3 = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    e3 = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (b3 !== 1'b0 || v3 !== 1'b0 || ld3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_abort_now: busy=%b valid=%b data=%h required 0/0/0", b3, v3, ld3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (v3 !== 1'b0 || b3 !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_abort_after: valid or busy seen=%b required 0", seen);
    end
    @(negedge clk);
    e3 = 1'b1; a3 = 32'h41; sel3 = 3'b110;
    @(posedge clk); #1;
    @(negedge clk);
    e3 = 1'b0;
    lat = 1;
    while (v3 !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (v3 !== 1'b1 || lat != 4 || ld3 !== 32'h000000F0) begin
      n_fail++;
      $display("FAIL ram_after_reset: valid=%b latency=%0d data=%h required 1/4/000000f0",
               v3, lat, ld3);
    end
  endtask

  initial begin
    test_reset();
    test_word_and_bytes();
    test_hold();
    test_half();
    test_alias();
    test_random_back_to_back();
    test_wait_states();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
